l1v_hakem: RTL and testbench

// - Shares the single L1 data memory port between two requesters: r0 = bellek islem birimi (load/store) and r1 = second master (DMA/debug).
// - Round-robin arbiter plus an access sequencer. Latches the granted request, drives the l1v_* port, waits out l1v_durdur_i, then returns read data with a completion pulse.
// - Sits between yurut and the L1 veri bellegi.

---
 rtl/l1v_hakem.sv | 179 +++++++++++++++++
 tb/tb_l1v_hakem.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1v_hakem.sv
// Round-robin arbiter and access sequencer sharing the L1 data port between r0 and r1.
// Optional timeout: define L1V_HAKEM_ZAMAN_ASIMI_EN to abort stalled accesses after ZA_SINIR cycles.
module l1v_hakem #(
  parameter int unsigned ADR_BIT  = 32,
  parameter int unsigned VERI_BIT = 32,
  parameter int unsigned ZA_SINIR = 1023
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  r0_istek_i,
  input  logic [ADR_BIT-1:0]    r0_adr_i,
  input  logic [VERI_BIT-1:0]   r0_veri_i,
  input  logic [VERI_BIT/8-1:0] r0_maske_i,
  input  logic                  r0_yaz_i,
  output logic                  r0_kabul_o,
  output logic                  r0_bitti_o,
  output logic [VERI_BIT-1:0]   r0_veri_o,
  input  logic                  r1_istek_i,
  input  logic [ADR_BIT-1:0]    r1_adr_i,
  input  logic [VERI_BIT-1:0]   r1_veri_i,
  input  logic [VERI_BIT/8-1:0] r1_maske_i,
  input  logic                  r1_yaz_i,
  output logic                  r1_kabul_o,
  output logic                  r1_bitti_o,
  output logic [VERI_BIT-1:0]   r1_veri_o,
  output logic                  hata_o,
  input  logic [VERI_BIT-1:0]   l1v_veri_i,
  input  logic                  l1v_durdur_i,
  output logic [ADR_BIT-1:0]    l1v_adr_o,
  output logic [VERI_BIT-1:0]   l1v_veri_o,
  output logic [VERI_BIT/8-1:0] l1v_veri_maske_o,
  output logic                  l1v_yaz_gecerli_o,
  output logic                  l1v_sec_n_o
);

  localparam int unsigned MASKE_BIT = VERI_BIT / 8;

  if (ZA_SINIR < 1) begin : g_za_sinir_kontrol
    $error("l1v_hakem: ZA_SINIR must be at least 1");
  end

  typedef enum logic [1:0] {
    BOSTA  = 2'd0,
    MESGUL = 2'd1,
    TAMAM  = 2'd2
  } durum_e;

  durum_e                durum_q, durum_d;
  logic                  sahip_q, sahip_d;
  logic                  son_q, son_d;
  logic [ADR_BIT-1:0]    adr_q, adr_d;
  logic [VERI_BIT-1:0]   veri_q, veri_d;
  logic [MASKE_BIT-1:0]  maske_q, maske_d;
  logic                  yaz_q, yaz_d;
  logic [1:0]            kabul_q, kabul_d;
  logic [VERI_BIT-1:0]   oku0_q, oku0_d;
  logic [VERI_BIT-1:0]   oku1_q, oku1_d;
  logic                  secilen;
  logic [VERI_BIT-1:0]   oku;

`ifdef L1V_HAKEM_ZAMAN_ASIMI_EN
  localparam int unsigned ZA_W = $clog2(ZA_SINIR + 1);
  logic [ZA_W-1:0] sayac_q, sayac_d;
  logic            hata_q, hata_d;
`endif

  always_comb begin
    durum_d = durum_q;
    sahip_d = sahip_q;
    son_d   = son_q;
    adr_d   = adr_q;
    veri_d  = veri_q;
    maske_d = maske_q;
    yaz_d   = yaz_q;
    kabul_d = '0;
    oku0_d  = oku0_q;
    oku1_d  = oku1_q;
    secilen = 1'b0;
    oku     = '0;
`ifdef L1V_HAKEM_ZAMAN_ASIMI_EN
    sayac_d = sayac_q;
    hata_d  = 1'b0;
`endif
    unique case (durum_q)
      BOSTA: begin
        if (r0_istek_i || r1_istek_i) begin
          // With both pending the port that did not win last time goes first.
          secilen = (r0_istek_i && r1_istek_i) ? ~son_q : r1_istek_i;
          adr_d   = secilen ? r1_adr_i   : r0_adr_i;
          veri_d  = secilen ? r1_veri_i  : r0_veri_i;
          maske_d = secilen ? r1_maske_i : r0_maske_i;
          yaz_d   = secilen ? r1_yaz_i   : r0_yaz_i;
          sahip_d = secilen;
          son_d   = secilen;
          kabul_d = secilen ? 2'b10 : 2'b01;
          durum_d = MESGUL;
`ifdef L1V_HAKEM_ZAMAN_ASIMI_EN
          sayac_d = '0;
`endif
        end
      end
      MESGUL: begin
        if (!l1v_durdur_i) begin
          oku = yaz_q ? '0 : l1v_veri_i;
          if (sahip_q) oku1_d = oku;
          else         oku0_d = oku;
          durum_d = TAMAM;
        end
`ifdef L1V_HAKEM_ZAMAN_ASIMI_EN
        else if (sayac_q == ZA_W'(ZA_SINIR - 1)) begin
          if (sahip_q) oku1_d = '0;
          else         oku0_d = '0;
          hata_d  = 1'b1;
          durum_d = TAMAM;
        end else begin
          sayac_d = sayac_q + 1'b1;
        end
`endif
      end
      TAMAM:   durum_d = BOSTA;
      default: durum_d = BOSTA;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      durum_q <= BOSTA;
      sahip_q <= 1'b0;
      son_q   <= 1'b1;
      adr_q   <= '0;
      veri_q  <= '0;
      maske_q <= '0;
      yaz_q   <= 1'b0;
      kabul_q <= '0;
      oku0_q  <= '0;
      oku1_q  <= '0;
    end else begin
      durum_q <= durum_d;
      sahip_q <= sahip_d;
      son_q   <= son_d;
      adr_q   <= adr_d;
      veri_q  <= veri_d;
      maske_q <= maske_d;
      yaz_q   <= yaz_d;
      kabul_q <= kabul_d;
      oku0_q  <= oku0_d;
      oku1_q  <= oku1_d;
    end
  end

`ifdef L1V_HAKEM_ZAMAN_ASIMI_EN
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      sayac_q <= '0;
      hata_q  <= 1'b0;
    end else begin
      sayac_q <= sayac_d;
      hata_q  <= hata_d;
    end
  end

  assign hata_o = hata_q;
`else
  assign hata_o = 1'b0;
`endif

  assign r0_kabul_o        = kabul_q[0];
  assign r1_kabul_o        = kabul_q[1];
  assign r0_bitti_o        = (durum_q == TAMAM) && !sahip_q;
  assign r1_bitti_o        = (durum_q == TAMAM) && sahip_q;
  assign r0_veri_o         = oku0_q;
  assign r1_veri_o         = oku1_q;
  assign l1v_adr_o         = adr_q;
  assign l1v_veri_o        = veri_q;
  assign l1v_veri_maske_o  = maske_q;
  assign l1v_yaz_gecerli_o = yaz_q && (durum_q == MESGUL);
  assign l1v_sec_n_o       = (durum_q != MESGUL);

endmodule

// File: tb/tb_l1v_hakem.sv
// Bench for l1v_hakem: table-driven single transactions, hand-written corner sequences,
// and a randomized run against a transaction-level reference model.
module tb_l1v_hakem;

  localparam int unsigned TB_ZA = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        istek [2];
  logic [31:0] adr   [2];
  logic [31:0] wd    [2];
  logic [3:0]  msk   [2];
  logic        yaz   [2];
  logic        kabul0, kabul1, bitti0, bitti1, hata;
  logic [31:0] rd0, rd1;
  logic [31:0] l1v_rd;
  logic        durdur;
  logic [31:0] l1_adr, l1_wd;
  logic [3:0]  l1_msk;
  logic        l1_yaz, sec_n;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  l1v_hakem #(.ADR_BIT(32), .VERI_BIT(32), .ZA_SINIR(TB_ZA)) dut (
    .clk_i(clk), .rst_i(rst),
    .r0_istek_i(istek[0]), .r0_adr_i(adr[0]), .r0_veri_i(wd[0]), .r0_maske_i(msk[0]), .r0_yaz_i(yaz[0]),
    .r0_kabul_o(kabul0), .r0_bitti_o(bitti0), .r0_veri_o(rd0),
    .r1_istek_i(istek[1]), .r1_adr_i(adr[1]), .r1_veri_i(wd[1]), .r1_maske_i(msk[1]), .r1_yaz_i(yaz[1]),
    .r1_kabul_o(kabul1), .r1_bitti_o(bitti1), .r1_veri_o(rd1),
    .hata_o(hata),
    .l1v_veri_i(l1v_rd), .l1v_durdur_i(durdur),
    .l1v_adr_o(l1_adr), .l1v_veri_o(l1_wd), .l1v_veri_maske_o(l1_msk),
    .l1v_yaz_gecerli_o(l1_yaz), .l1v_sec_n_o(sec_n)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    istek[0] = 1'b0;
    istek[1] = 1'b0;
    durdur = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  // ---------------- table-driven single transactions ----------------
  typedef struct {
    int          port;
    logic        yaz;
    logic [31:0] adr;
    logic [31:0] wd;
    logic [3:0]  msk;
    int          stalls;
    logic [31:0] l1rd;
    logic [31:0] exp_rd;
    int          exp_lat;
  } vec_t;

  vec_t tbl [5];

  task automatic run_txn(input vec_t v);
    int p;
    bit got;
    p = v.port;
    istek[p] = 1'b1;
    adr[p] = v.adr;
    wd[p] = v.wd;
    msk[p] = v.msk;
    yaz[p] = v.yaz;
    durdur = (v.stalls > 0);
    l1v_rd = v.l1rd;
    got = 1'b0;
    for (int c = 1; c <= 20 && !got; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        chk("t_kabul", p ? kabul1 : kabul0, 1);
        chk("t_kabul_other", p ? kabul0 : kabul1, 0);
      end
      if (c < v.exp_lat) begin
        chk("t_sec_n", sec_n, 0);
        chk("t_l1_adr", l1_adr, v.adr);
        chk("t_l1_wd", l1_wd, v.wd);
        chk("t_l1_msk", l1_msk, v.msk);
        chk("t_l1_yaz", l1_yaz, v.yaz);
      end
      if ((p ? bitti1 : bitti0) === 1'b1) begin
        got = 1'b1;
        chk("t_latency", c, v.exp_lat);
        chk("t_rdata", p ? rd1 : rd0, v.exp_rd);
        chk("t_bitti_other", p ? bitti0 : bitti1, 0);
        istek[p] = 1'b0;
      end
      durdur = (c <= v.stalls);
    end
    if (!got) chk("t_bitti_timeout", 0, 1);
    istek[p] = 1'b0;
    durdur = 1'b0;
    @(posedge clk); #1;
    chk("t_rdata_hold", p ? rd1 : rd0, v.exp_rd);
    chk("t_idle_sec_n", sec_n, 1);
  endtask

  // ---------------- transaction-level reference model ----------------
  int          m_owner, m_done, m_last, m_stall;
  bit          m_hata;
  bit          m_kab [2];
  logic [31:0] m_adr, m_wd;
  logic [3:0]  m_msk;
  bit          m_yaz;
  logic [31:0] m_rd [2];

  task automatic m_reset();
    m_owner = -1; m_done = -1; m_last = 1; m_stall = 0; m_hata = 0;
    m_kab[0] = 0; m_kab[1] = 0;
    m_adr = '0; m_wd = '0; m_msk = '0; m_yaz = 0;
    m_rd[0] = '0; m_rd[1] = '0;
  endtask

  // Advance one clock: the access being served, who is next, what the requester gets back.
  task automatic m_step();
    int w;
    m_kab[0] = 0; m_kab[1] = 0;
    m_hata = 0;
    if (m_done >= 0) begin
      m_done = -1;
    end else if (m_owner < 0) begin
      if (istek[0] || istek[1]) begin
        if (istek[0] && istek[1]) w = 1 - m_last;
        else                      w = istek[1] ? 1 : 0;
        m_adr = adr[w]; m_wd = wd[w]; m_msk = msk[w]; m_yaz = yaz[w];
        m_last = w; m_owner = w; m_kab[w] = 1; m_stall = 0;
      end
    end else if (!durdur) begin
      m_rd[m_owner] = m_yaz ? 32'h0 : l1v_rd;
      m_done = m_owner;
      m_owner = -1;
    end else begin
`ifdef L1V_HAKEM_ZAMAN_ASIMI_EN
      m_stall++;
      if (m_stall == TB_ZA) begin
        m_rd[m_owner] = 32'h0;
        m_done = m_owner;
        m_owner = -1;
        m_hata = 1;
      end
`endif
    end
  endtask

  task automatic m_check();
    chk("r_sec_n", sec_n, (m_owner < 0));
    chk("r_kabul0", kabul0, m_kab[0]);
    chk("r_kabul1", kabul1, m_kab[1]);
    chk("r_bitti0", bitti0, (m_done == 0));
    chk("r_bitti1", bitti1, (m_done == 1));
    chk("r_rd0", rd0, m_rd[0]);
    chk("r_rd1", rd1, m_rd[1]);
    chk("r_l1_adr", l1_adr, m_adr);
    chk("r_l1_wd", l1_wd, m_wd);
    chk("r_l1_msk", l1_msk, m_msk);
    chk("r_l1_yaz", l1_yaz, (m_owner >= 0) && m_yaz);
    chk("r_hata", hata, m_hata);
  endtask

  int rq [2];
  int gap [2];

  task automatic drive_update();
    durdur = ($urandom_range(0, 3) == 0);
    l1v_rd = $urandom;
    for (int p = 0; p < 2; p++) begin
      if (m_done == p) begin
        istek[p] = 1'b0;
        rq[p] = 0;
        gap[p] = $urandom_range(0, 2);
      end else if (rq[p] == 0) begin
        if (gap[p] == 0) begin
          istek[p] = 1'b1;
          adr[p] = $urandom;
          wd[p] = $urandom;
          msk[p] = 4'($urandom_range(0, 15));
          yaz[p] = 1'($urandom_range(0, 1));
          rq[p] = 1;
        end else begin
          gap[p]--;
        end
      end else if (rq[p] == 1 && m_kab[p]) begin
        rq[p] = 2;
        if ($urandom_range(0, 3) == 0) begin
          adr[p] = $urandom;
          wd[p] = $urandom;
        end
        if ($urandom_range(0, 3) == 0) istek[p] = 1'b0;
      end
    end
  endtask

  initial begin
    int order [$];
    bit got;
    bit seen;

    tbl[0] = '{port: 0, yaz: 1'b0, adr: 32'h100,      wd: 32'h0,        msk: 4'hF, stalls: 0, l1rd: 32'hDEADBEEF, exp_rd: 32'hDEADBEEF, exp_lat: 2};
    tbl[1] = '{port: 1, yaz: 1'b1, adr: 32'h40,       wd: 32'hA5,       msk: 4'h1, stalls: 5, l1rd: 32'h12345678, exp_rd: 32'h0,        exp_lat: 7};
    tbl[2] = '{port: 1, yaz: 1'b0, adr: 32'h2000,     wd: 32'h0,        msk: 4'hF, stalls: 1, l1rd: 32'hCAFEF00D, exp_rd: 32'hCAFEF00D, exp_lat: 3};
    tbl[3] = '{port: 0, yaz: 1'b1, adr: 32'hFFFFFFFC, wd: 32'hFFFFFFFF, msk: 4'hF, stalls: 2, l1rd: 32'h55,       exp_rd: 32'h0,        exp_lat: 4};
    tbl[4] = '{port: 0, yaz: 1'b0, adr: 32'h0,        wd: 32'h0,        msk: 4'h0, stalls: 3, l1rd: 32'h1,        exp_rd: 32'h1,        exp_lat: 5};

    for (int p = 0; p < 2; p++) begin
      istek[p] = 1'b0; adr[p] = '0; wd[p] = '0; msk[p] = '0; yaz[p] = 1'b0;
      rq[p] = 0; gap[p] = 0;
    end
    durdur = 1'b0;
    l1v_rd = '0;
    rst = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sec_n", sec_n, 1);
    chk("rst_kabul", {kabul1, kabul0}, 0);
    chk("rst_bitti", {bitti1, bitti0}, 0);
    chk("rst_rd0", rd0, 0);
    chk("rst_rd1", rd1, 0);
    chk("rst_l1_adr", l1_adr, 0);
    chk("rst_l1_yaz", l1_yaz, 0);
    chk("rst_hata", hata, 0);
    rst = 1'b1;

    for (int i = 0; i < 5; i++) run_txn(tbl[i]);

    // r0 drops istek and changes adr after kabul; latched fields must hold
    istek[0] = 1'b1; adr[0] = 32'h300; wd[0] = 32'h1111; msk[0] = 4'h3; yaz[0] = 1'b0;
    durdur = 1'b1; l1v_rd = 32'hBEEF0300;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        chk("drop_kabul", kabul0, 1);
        istek[0] = 1'b0; adr[0] = 32'h999; wd[0] = 32'h2222;
      end
      if (c <= 3) begin
        chk("drop_sec_n", sec_n, 0);
        chk("drop_l1_adr", l1_adr, 32'h300);
        chk("drop_l1_wd", l1_wd, 32'h1111);
      end
      if (c == 4) begin
        chk("drop_bitti", bitti0, 1);
        chk("drop_rd", rd0, 32'hBEEF0300);
      end
      durdur = (c <= 2);
    end
    @(posedge clk); #1;

    // Indefinite stall: timeout when enabled, otherwise wait forever for durdur
    istek[0] = 1'b1; adr[0] = 32'h500; yaz[0] = 1'b0; durdur = 1'b1; l1v_rd = 32'h5A5A5A5A;
`ifdef L1V_HAKEM_ZAMAN_ASIMI_EN
    got = 1'b0;
    for (int c = 1; c <= 15 && !got; c++) begin
      @(posedge clk); #1;
      if (bitti0 === 1'b1) begin
        got = 1'b1;
        chk("za_latency", c, TB_ZA + 1);
        chk("za_hata", hata, 1);
        chk("za_rd", rd0, 0);
        istek[0] = 1'b0;
      end else begin
        chk("za_hata_early", hata, 0);
      end
    end
    if (!got) chk("za_bitti_timeout", 0, 1);
    istek[0] = 1'b0;
    durdur = 1'b0;
    @(posedge clk); #1;
`else
    seen = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      @(posedge clk); #1;
      if (bitti0 === 1'b1) seen = 1'b1;
    end
    chk("stall_no_bitti", seen, 0);
    chk("stall_sec_n", sec_n, 0);
    chk("stall_hata", hata, 0);
    durdur = 1'b0;
    @(posedge clk); #1;
    chk("stall_bitti", bitti0, 1);
    chk("stall_rd", rd0, 32'h5A5A5A5A);
    istek[0] = 1'b0;
    @(posedge clk); #1;
`endif

    // Both ports requesting continuously: r0, r1, r0, r1
    do_reset();
    istek[0] = 1'b1; adr[0] = 32'hA0; yaz[0] = 1'b0;
    istek[1] = 1'b1; adr[1] = 32'hB1; yaz[1] = 1'b0;
    durdur = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      chk("rr_one_kabul", kabul0 & kabul1, 0);
      chk("rr_one_bitti", bitti0 & bitti1, 0);
      if (kabul0 === 1'b1) begin order.push_back(0); chk("rr_adr0", l1_adr, 32'hA0); end
      if (kabul1 === 1'b1) begin order.push_back(1); chk("rr_adr1", l1_adr, 32'hB1); end
    end
    chk("rr_count", order.size(), 4);
    if (order.size() == 4) begin
      chk("rr_g0", order[0], 0);
      chk("rr_g1", order[1], 1);
      chk("rr_g2", order[2], 0);
      chk("rr_g3", order[3], 1);
    end

    // Reset during MESGUL aborts; next grant goes to r0
    do_reset();
    istek[1] = 1'b1; adr[1] = 32'h77; wd[1] = '0; msk[1] = 4'hF; yaz[1] = 1'b0;
    durdur = 1'b1;
    @(posedge clk); #1;
    chk("ra_kabul1", kabul1, 1);
    chk("ra_sec_n", sec_n, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    chk("ra_abort_sec_n", sec_n, 1);
    chk("ra_no_bitti", {bitti1, bitti0}, 0);
    istek[0] = 1'b1; adr[0] = 32'h88; yaz[0] = 1'b0;
    durdur = 1'b0;
    @(posedge clk); #1;
    chk("ra_next_r0", kabul0, 1);
    chk("ra_not_r1", kabul1, 0);
    chk("ra_l1_adr", l1_adr, 32'h88);
    @(posedge clk); #1;
    chk("ra_bitti0", bitti0, 1);
    istek[0] = 1'b0; istek[1] = 1'b0;
    @(posedge clk); #1;

    // Randomized traffic against the model
    do_reset();
    m_reset();
    for (int p = 0; p < 2; p++) begin rq[p] = 0; gap[p] = 0; end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      m_step();
      @(posedge clk); #1;
      m_check();
      drive_update();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
